pool_engine: RTL and testbench

2x2 stride-2 max-pooling engine driven by the APB pooling register block. Control and geometry come from that block: pool_start, width, length, height, data_size. The engine returns pool_done and clk_counter to it. Reads the input feature map from a synchronous-read buffer and writes pooled elements to an output buffer.

---
 rtl/pool_engine_if.sv | 30 +++
 rtl/pool_engine.sv | 162 ++++++++++++++++
 tb/tb_pool_engine.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_engine_if.sv
// Bundles the register-block control and the input/output buffer buses of the
// 2x2 max-pooling engine. The engine connects through the master modport.
interface pool_engine_if #(
  parameter int DW = 8,
  parameter int AW = 16
);
  logic          pool_start;
  logic [7:0]    width;
  logic [8:0]    length;
  logic [7:0]    height;
  logic [10:0]   data_size;
  logic          pool_done;
  logic [31:0]   clk_counter;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    input  pool_start, width, length, height, data_size, rd_data,
    output pool_done, clk_counter, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output pool_start, width, length, height, data_size, rd_data,
    input  pool_done, clk_counter, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pool_engine.sv
// 2x2 stride-2 signed max-pooling engine: four reads then one write per window,
// walking channel, output row, output column; counts busy cycles per run.
module pool_engine #(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic          PCLK,
  input  logic          PRESETB,
  pool_engine_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, DONE} state_t;

  state_t               state, state_nxt;
  logic                 start_q;
  logic                 start_evt;
  logic [7:0]           w_q, h_q;
  logic [8:0]           l_q;
  logic [10:0]          ob_q;
  logic [6:0]           ow_q, oh_q;
  logic [6:0]           ow_in, oh_in;
  logic [8:0]           c;
  logic [6:0]           orow, ocol;
  logic [1:0]           k;
  logic [AW-1:0]        n;
  logic signed [DW-1:0] acc;
  logic signed [DW-1:0] rd_s;
  logic [31:0]          cnt, cnt_inc;
  logic [AW-1:0]        base, offset;
  logic                 last_col, last_row, last_chan;

  assign start_evt = bus.pool_start & ~start_q;
  assign ow_in     = bus.width[7:1];
  assign oh_in     = bus.height[7:1];
  assign rd_s      = signed'(bus.rd_data);
  assign cnt_inc   = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;

  assign last_col  = (ocol == ow_q - 7'd1);
  assign last_row  = (orow == oh_q - 7'd1);
  assign last_chan = (c == l_q - 9'd1);

  // Top-left element of the current window, wrapping modulo 2^AW.
  assign base = (AW'(c) * AW'(h_q) + AW'({orow, 1'b0})) * AW'(w_q) + AW'({ocol, 1'b0});

  always_comb begin
    offset = '0;
    case (k)
      2'd1:    offset = AW'(1);
      2'd2:    offset = AW'(w_q);
      2'd3:    offset = AW'(w_q) + AW'(1);
      default: offset = '0;
    endcase
  end

  assign bus.clk_counter = cnt;

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output and the next state get a default before the case, so
  // no path through this block leaves a value unassigned and no latch appears.
  always_comb begin
    state_nxt     = state;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.pool_done = 1'b0;
    unique case (state)
      IDLE: if (start_evt) state_nxt = LOAD;
      LOAD: begin
        if (ow_in == 7'd0 || oh_in == 7'd0 || bus.length == 9'd0) state_nxt = DONE;
        else                                                       state_nxt = READ;
      end
      READ: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = base + offset;
        if (k == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        // The fourth element arrives this cycle and is folded in directly.
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(ob_q) + n;
        bus.wr_data = (rd_s > acc) ? rd_s : acc;
        state_nxt   = (last_col && last_row && last_chan) ? DONE : READ;
      end
      DONE: begin
        bus.pool_done = 1'b1;
        if (!bus.pool_start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      start_q <= 1'b0;
      w_q     <= '0;
      h_q     <= '0;
      l_q     <= '0;
      ob_q    <= '0;
      ow_q    <= '0;
      oh_q    <= '0;
      c       <= '0;
      orow    <= '0;
      ocol    <= '0;
      k       <= '0;
      n       <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      start_q <= bus.pool_start;
      case (state)
        IDLE: if (start_evt) cnt <= '0;
        LOAD: begin
          w_q  <= bus.width;
          h_q  <= bus.height;
          l_q  <= bus.length;
          ob_q <= bus.data_size;
          ow_q <= ow_in;
          oh_q <= oh_in;
          c    <= '0;
          orow <= '0;
          ocol <= '0;
          k    <= '0;
          n    <= '0;
          cnt  <= cnt_inc;
        end
        READ: begin
          k   <= k + 2'd1;
          cnt <= cnt_inc;
          // Data returned here belongs to the read issued one cycle earlier.
          if (k == 2'd1)                   acc <= rd_s;
          else if (k != 2'd0 && rd_s > acc) acc <= rd_s;
        end
        WRITE: begin
          k   <= '0;
          n   <= n + AW'(1);
          cnt <= cnt_inc;
          if (last_col) begin
            ocol <= '0;
            if (last_row) begin
              orow <= '0;
              c    <= c + 9'd1;
            end else begin
              orow <= orow + 7'd1;
            end
          end else begin
            ocol <= ocol + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Self-checking bench for pool_engine: a loop-based reference builds the expected
// read/write streams from the window rules; a negedge monitor compares every strobe.
module tb_pool_engine;

  logic pclk;
  logic presetb;

  pool_engine_if #(.DW(8), .AW(16)) bus ();

  pool_engine #(.DW(8), .AW(16)) dut (
    .PCLK    (pclk),
    .PRESETB (presetb),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];
  logic [15:0] rd_log[$];
  wr_t         wr_log[$];
  int          nchk = 0;
  int          nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read input buffer: data valid one cycle after rd_en.
  initial bus.rd_data = '0;
  always @(posedge pclk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  always @(negedge pclk) begin
    if (bus.rd_en && bus.wr_en) check("rd_wr_overlap", 1, 0);
    if (bus.rd_en) begin
      rd_log.push_back(bus.rd_addr);
      if (exp_rd.size() == 0) check("rd_unexpected", {48'd0, bus.rd_addr}, 64'hDEAD);
      else                    check("rd_addr", bus.rd_addr, exp_rd.pop_front());
    end
    if (bus.wr_en) begin
      wr_t w;
      wr_log.push_back('{bus.wr_addr, bus.wr_data});
      if (exp_wr.size() == 0) check("wr_unexpected", {48'd0, bus.wr_addr}, 64'hDEAD);
      else begin
        w = exp_wr.pop_front();
        check("wr_addr", bus.wr_addr, w.a);
        check("wr_data", bus.wr_data, w.d);
      end
    end
  end

  // Reference: enumerate every window and take the signed max of its 4 elements.
  task automatic build(input int w, input int h, input int l, input int ob);
    int n = 0;
    exp_rd.delete();
    exp_wr.delete();
    for (int ch = 0; ch < l; ch++)
      for (int r = 0; r < h / 2; r++)
        for (int col = 0; col < w / 2; col++) begin
          int          top = (ch * h + 2 * r) * w + 2 * col;
          int          addrs [4];
          logic [15:0] a16;
          int          mx = -1000;
          addrs[0] = top;     addrs[1] = top + 1;
          addrs[2] = top + w; addrs[3] = top + w + 1;
          for (int i = 0; i < 4; i++) begin
            a16 = 16'(addrs[i]);
            exp_rd.push_back(a16);
            if (int'($signed(mem[a16])) > mx) mx = int'($signed(mem[a16]));
          end
          exp_wr.push_back('{16'(ob + n), 8'(mx)});
          n++;
        end
  endtask

  task automatic run(input int w, input int h, input int l, input int ob,
                     input bit hold, input bit wchg);
    bit seen = 0;
    build(w, h, l, ob);
    rd_log.delete();
    wr_log.delete();
    @(posedge pclk); #1;
    bus.width      = 8'(w);
    bus.height     = 8'(h);
    bus.length     = 9'(l);
    bus.data_size  = 11'(ob);
    bus.pool_start = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    check("cnt_clear", bus.clk_counter, 0);
    if (!hold) bus.pool_start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge pclk);
      if (wchg && i == 3) bus.width = 8'(w + 3);
      if (bus.pool_done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", seen, 1);
    check("cnt_final", bus.clk_counter, 1 + 5 * l * (h / 2) * (w / 2));
    check("rd_left", exp_rd.size(), 0);
    check("wr_left", exp_wr.size(), 0);
    if (!hold) begin
      @(negedge pclk);
      check("done_drop", bus.pool_done, 0);
    end
    bus.width = 8'(w);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rd_en"},   bus.rd_en, 0);
    check({name, "_rd_addr"}, bus.rd_addr, 0);
    check({name, "_wr_en"},   bus.wr_en, 0);
    check({name, "_wr_addr"}, bus.wr_addr, 0);
    check({name, "_wr_data"}, bus.wr_data, 0);
    check({name, "_done"},    bus.pool_done, 0);
    check({name, "_cnt"},     bus.clk_counter, 0);
  endtask

  initial begin
    int bad;
    bit hit;
    presetb        = 1'b0;
    bus.pool_start = 1'b0;
    bus.width      = '0;
    bus.height     = '0;
    bus.length     = '0;
    bus.data_size  = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    repeat (3) @(negedge pclk);
    check_idle_outputs("reset");
    @(posedge pclk); #1 presetb = 1'b1;
    repeat (2) @(negedge pclk);

    // Basic 4x4 single channel, with pinned literal results.
    run(4, 4, 1, 0, 0, 0);
    check("basic_cnt", bus.clk_counter, 21);
    check("basic_nwr", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("basic_a0", wr_log[0].a, 0);  check("basic_d0", wr_log[0].d, 5);
      check("basic_a1", wr_log[1].a, 1);  check("basic_d1", wr_log[1].d, 7);
      check("basic_a2", wr_log[2].a, 2);  check("basic_d2", wr_log[2].d, 13);
      check("basic_a3", wr_log[3].a, 3);  check("basic_d3", wr_log[3].d, 15);
    end

    // Signed compare: all negatives, max is -1.
    mem[0] = 8'hFB; mem[1] = 8'hFD; mem[2] = 8'h80; mem[3] = 8'hFF;
    run(2, 2, 1, 7, 0, 0);
    check("signed_cnt", bus.clk_counter, 6);
    check("signed_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      check("signed_addr", wr_log[0].a, 7);
      check("signed_data", wr_log[0].d, 8'hFF);
    end

    // Odd dimensions, two channels, pseudo-random signed data.
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) & 255);
    run(5, 3, 2, 100, 0, 0);
    check("odd_cnt", bus.clk_counter, 21);
    check("odd_nrd", rd_log.size(), 16);
    if (rd_log.size() == 16) begin
      check("odd_base0", rd_log[0], 0);
      check("odd_base1", rd_log[4], 2);
      check("odd_base2", rd_log[8], 15);
      check("odd_base3", rd_log[12], 17);
    end
    bad = 0;
    foreach (rd_log[i])
      if (rd_log[i] % 5 == 4 || (rd_log[i] % 15) / 5 == 2) bad++;
    check("odd_edge_reads", bad, 0);
    check("odd_nwr", wr_log.size(), 4);
    foreach (wr_log[i]) check("odd_wr_addr", wr_log[i].a, 100 + i);

    // Degenerate geometries: no strobes, one busy cycle.
    run(1, 4, 1, 0, 0, 0);
    check("degen_w_cnt", bus.clk_counter, 1);
    check("degen_w_strobes", rd_log.size() + wr_log.size(), 0);
    run(4, 4, 0, 0, 0, 0);
    check("degen_l_cnt", bus.clk_counter, 1);
    check("degen_l_strobes", rd_log.size() + wr_log.size(), 0);

    // Handshake: hold start after done, then drop, then restart.
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    run(4, 4, 1, 0, 1, 0);
    repeat (5) begin
      @(negedge pclk);
      check("hold_done", bus.pool_done, 1);
      check("hold_cnt", bus.clk_counter, 21);
    end
    @(posedge pclk); #1 bus.pool_start = 1'b0;
    @(negedge pclk);
    check("drop_done_still", bus.pool_done, 1);
    @(negedge pclk);
    check("drop_done_low", bus.pool_done, 0);
    check("idle_cnt_hold", bus.clk_counter, 21);
    run(6, 4, 3, 2040, 0, 0);

    // Width change mid-run must not disturb the addresses.
    run(4, 4, 2, 50, 0, 1);

    // Reset in the middle of READ, then a clean run.
    build(4, 4, 1, 0);
    @(posedge pclk); #1 bus.pool_start = 1'b1;
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      if (bus.rd_en) begin
        hit = 1;
        break;
      end
    end
    check("rst_reached_read", hit, 1);
    @(posedge pclk); #1 presetb = 1'b0;
    bus.pool_start = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    #1 check_idle_outputs("rst_mid");
    repeat (4) @(negedge pclk);
    check_idle_outputs("rst_hold");
    @(posedge pclk); #1 presetb = 1'b1;
    repeat (3) @(negedge pclk);
    check("rst_after_done", bus.pool_done, 0);
    run(4, 4, 1, 0, 0, 0);
    check("rst_rerun_cnt", bus.clk_counter, 21);
    check("rst_rerun_nwr", wr_log.size(), 4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
